id_ex_pipe_reg: RTL
===================

Name: id_ex_pipe_reg

Overview:
Parametrised ID→EX pipeline register for the pipelined datapath, carrying RegWrite, ALUSrc, operand data, immediate and register numbers.
Adds a valid/ready handshake with a 2-entry skid buffer, so EX can stall without a combinational ready path back to ID.
Adds a flush input for bubble insertion.
Full-width register numbers are carried, so EX-stage hazard logic can use them.

Parameters:
DATA_W, 8, width of Read_Data and ID_EX_Read_Data
IMM_W, 8, width of the immediate field
REG_ADDR_W, 3, width of register numbers (register file depth = 2**REG_ADDR_W)

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  asynchronous, active-high reset
in_valid  in  1  ID presents a valid instruction
in_ready  out  1  stage can accept; registered, not combinational from out_ready
flush  in  1  discard every held entry and the incoming beat this cycle
IF_ID_RegWrite  in  1  register-write enable of the incoming instruction
IF_ID_ALUSrc  in  1  ALU operand select (1 = immediate)
Read_Data  in  DATA_W  register-file read value
IF_ID_Imm_Data  in  IMM_W  immediate
Read_Reg_Num  in  REG_ADDR_W  source register number
Write_Reg_Num  in  REG_ADDR_W  destination register number
out_valid  out  1  EX-side payload valid
out_ready  in  1  EX accepts the payload
ID_EX_RegWrite  out  1  registered RegWrite, forced 0 when out_valid=0
ID_EX_ALUSrc  out  1  registered ALUSrc
ID_EX_Read_Data  out  DATA_W  registered operand
ID_EX_Imm_Data  out  IMM_W  registered immediate
ID_EX_Read_Reg_Num  out  REG_ADDR_W  registered source register number
ID_EX_Write_Reg_Num  out  REG_ADDR_W  registered destination register number (full width)

Behaviour:
- Storage: main slot (drives outputs) and skid slot, each with a valid flag.
- Transfer rules:
  - Accept when in_valid & in_ready.
  - Emit when out_valid & out_ready.
  - Latency: 1 cycle from accept to out_valid when main is empty or draining.
- Reset (asynchronous):
  - Both valid flags = 0 and all payload registers = 0.
  - Outputs read 0; out_valid = 0; in_ready = 1 on the first edge after Reset deasserts.
- Occupancy states: EMPTY, ONE (main only), FULL (main + skid). in_ready = !skid_valid, registered.
  - EMPTY + accept → ONE, payload written to main.
  - ONE + accept + emit → ONE, main reloaded.
  - ONE + accept + no emit → FULL, payload written to skid.
  - ONE + emit only → EMPTY.
  - FULL + emit → ONE, skid moves to main. No accept is possible in FULL.
- Stall: while out_ready = 0, all outputs are held bit-stable.
- flush has priority over every other event.
  - Next state is EMPTY; the incoming beat is dropped.
  - Payload registers keep their values; ID_EX_RegWrite still reads 0 because out_valid = 0.
- in_valid = 0 leaves payload registers unchanged. No X propagates to ID_EX_RegWrite.
- A Reset assertion mid-stall clears everything immediately, without waiting for a clock edge.
- No arithmetic. Widths pass through unchanged.

Optional Feature:
Macro WB_BYPASS_EN.
- Defined:
  - Adds ports WB_RegWrite (in, 1), WB_Write_Reg_Num (in, REG_ADDR_W) and WB_Write_Data (in, DATA_W).
  - On accept, if WB_RegWrite is set and WB_Write_Reg_Num == Read_Reg_Num, the captured Read_Data is WB_Write_Data.
  - Any held valid entry (main or skid) whose Read_Reg_Num matches a WB write in that cycle has its Read_Data overwritten, so stalled operands never go stale.
  - A simultaneous skid→main move carries the updated value.
- Undefined: the ports are absent and Read_Data is captured verbatim.

Decomposition:
- Package id_ex_pkg:
  - Struct id_ex_payload_t {regwrite, alusrc, read_data, imm, read_reg, write_reg}.
  - Localparam defaults for the three parameters.
- Sub-module pipe_skid_buf:
  - Generic 2-entry valid/ready skid buffer on an opaque payload vector.
  - id_ex_pipe_reg wraps it, adds the RegWrite masking, and adds the WB bypass update hook.

Test Plan:
- Reset mid-stream with FULL occupancy → same-cycle out_valid = 0 and all outputs 0; in_ready = 1 after the first Clk post-deassert.
- Stream beats Read_Data = 0x11, 0x22, 0x33 with out_ready = 1 → each appears 1 cycle later in order; in_ready stays 1.
- Accept 0xA1 then 0xA2, out_ready = 0 for 3 cycles → in_ready = 0 after the 2nd accept and outputs hold 0xA1; releasing out_ready emits 0xA1 then 0xA2, with no loss or duplication.
- flush asserted while FULL and in_valid = 1 with IF_ID_RegWrite = 1 → next cycle out_valid = 0 and ID_EX_RegWrite = 0; the dropped beat never appears.
- Write_Reg_Num = 3'b101, IF_ID_ALUSrc = 1, Imm = 0x7F → ID_EX_Write_Reg_Num = 3'b101 full width and ID_EX_Imm_Data = 0x7F.
- WB_BYPASS_EN: stalled main entry with Read_Reg_Num = 2, then WB writes r2 = 0x5C → ID_EX_Read_Data becomes 0x5C while stalled; a WB write to r3 leaves it unchanged.

Source files
------------

// File: rtl/id_ex_pkg.sv
// id_ex_pkg: shared types and default widths for the ID->EX pipeline register.
//   DATA_W_DEF / IMM_W_DEF / REG_ADDR_W_DEF : default parameter values
//   id_ex_payload_t : one ID->EX beat at the default widths
package id_ex_pkg;
   localparam int DATA_W_DEF     = 8;
   localparam int IMM_W_DEF      = 8;
   localparam int REG_ADDR_W_DEF = 3;

   typedef struct packed {
      logic                      regwrite;
      logic                      alusrc;
      logic [DATA_W_DEF-1:0]     read_data;
      logic [IMM_W_DEF-1:0]      imm;
      logic [REG_ADDR_W_DEF-1:0] read_reg;
      logic [REG_ADDR_W_DEF-1:0] write_reg;
   } id_ex_payload_t;
endpackage

// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf: generic 2-entry valid/ready skid buffer on an opaque W-bit payload.
// The main slot drives the output; the skid slot catches the beat accepted while
// the consumer stalls. in_ready is a flop, so there is no combinational path from
// out_ready to in_ready.
// Ports:
//   Clk, Reset (async, active-high), flush (drop everything, incl. incoming beat)
//   in_valid/in_ready/in_data   : producer side
//   out_valid/out_ready/out_data: consumer side (out_data = main slot)
//   skid_data                   : skid slot contents (for the owner's update hook)
//   main_fix/skid_fix           : owner-patched copies of main/skid, written back
//                                 whenever a valid entry is held or moved
module pipe_skid_buf #(
   parameter int W = 8
) (
   input  logic         Clk,
   input  logic         Reset,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic [W-1:0] skid_data,
   input  logic [W-1:0] main_fix,
   input  logic [W-1:0] skid_fix
);
   logic         main_v, skid_v, rdy_q;
   logic         main_v_n, skid_v_n;
   logic [W-1:0] main_q, skid_q, main_n, skid_n;
   logic         accept, emit;

   assign accept = in_valid & rdy_q;
   assign emit   = main_v & out_ready;

   always_comb begin
      main_v_n = main_v;
      skid_v_n = skid_v;
      main_n   = main_q;
      skid_n   = skid_q;
      if (flush) begin
         // payload registers are left alone; only the valid flags clear
         main_v_n = 1'b0;
         skid_v_n = 1'b0;
      end else if (skid_v) begin
         // FULL: rdy_q is low, so no accept can happen here
         if (emit) begin
            main_n   = skid_fix;
            skid_v_n = 1'b0;
         end else begin
            main_n = main_fix;
            skid_n = skid_fix;
         end
      end else if (main_v) begin
         if (accept && emit) begin
            main_n = in_data;
         end else if (accept) begin
            skid_n   = in_data;
            skid_v_n = 1'b1;
            main_n   = main_fix;
         end else if (emit) begin
            main_v_n = 1'b0;
         end else begin
            main_n = main_fix;
         end
      end else if (accept) begin
         main_n   = in_data;
         main_v_n = 1'b1;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         main_v <= 1'b0;
         skid_v <= 1'b0;
         rdy_q  <= 1'b0;
         main_q <= '0;
         skid_q <= '0;
      end else begin
         main_v <= main_v_n;
         skid_v <= skid_v_n;
         rdy_q  <= !skid_v_n;
         main_q <= main_n;
         skid_q <= skid_n;
      end
   end

   assign in_ready  = rdy_q;
   assign out_valid = main_v;
   assign out_data  = main_q;
   assign skid_data = skid_q;
endmodule

// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: ID->EX pipeline register with valid/ready handshake, 2-entry
// skid buffer and flush. ID_EX_RegWrite is masked by out_valid so a bubble never
// writes the register file.
// Optional macro WB_BYPASS_EN: adds WB_RegWrite/WB_Write_Reg_Num/WB_Write_Data;
// a WB write to a matching Read_Reg_Num replaces the operand on capture and in
// any held entry, so a stalled operand never goes stale.
// Ports: Clk, Reset (async, active-high); in_valid/in_ready, flush, IF_ID_* and
// Read_* inputs; out_valid/out_ready and registered ID_EX_* outputs.
module id_ex_pipe_reg
   import id_ex_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DEF,
   parameter int IMM_W      = IMM_W_DEF,
   parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  flush,
   input  logic                  IF_ID_RegWrite,
   input  logic                  IF_ID_ALUSrc,
   input  logic [DATA_W-1:0]     Read_Data,
   input  logic [IMM_W-1:0]      IF_ID_Imm_Data,
   input  logic [REG_ADDR_W-1:0] Read_Reg_Num,
   input  logic [REG_ADDR_W-1:0] Write_Reg_Num,
`ifdef WB_BYPASS_EN
   input  logic                  WB_RegWrite,
   input  logic [REG_ADDR_W-1:0] WB_Write_Reg_Num,
   input  logic [DATA_W-1:0]     WB_Write_Data,
`endif
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  ID_EX_RegWrite,
   output logic                  ID_EX_ALUSrc,
   output logic [DATA_W-1:0]     ID_EX_Read_Data,
   output logic [IMM_W-1:0]      ID_EX_Imm_Data,
   output logic [REG_ADDR_W-1:0] ID_EX_Read_Reg_Num,
   output logic [REG_ADDR_W-1:0] ID_EX_Write_Reg_Num
);
   // same layout as id_ex_payload_t, but sized by this instance's parameters
   typedef struct packed {
      logic                  regwrite;
      logic                  alusrc;
      logic [DATA_W-1:0]     read_data;
      logic [IMM_W-1:0]      imm;
      logic [REG_ADDR_W-1:0] read_reg;
      logic [REG_ADDR_W-1:0] write_reg;
   } payload_t;

   payload_t in_raw, in_p, main_p, skid_p, main_fix, skid_fix;

   assign in_raw = '{regwrite:  IF_ID_RegWrite,
                     alusrc:    IF_ID_ALUSrc,
                     read_data: Read_Data,
                     imm:       IF_ID_Imm_Data,
                     read_reg:  Read_Reg_Num,
                     write_reg: Write_Reg_Num};

`ifdef WB_BYPASS_EN
   function automatic payload_t wb_patch(input payload_t p);
      payload_t r;
      r = p;
      if (WB_RegWrite && (WB_Write_Reg_Num == p.read_reg))
         r.read_data = WB_Write_Data;
      return r;
   endfunction

   assign in_p     = wb_patch(in_raw);
   assign main_fix = wb_patch(main_p);
   assign skid_fix = wb_patch(skid_p);
`else
   assign in_p     = in_raw;
   assign main_fix = main_p;
   assign skid_fix = skid_p;
`endif

   pipe_skid_buf #(.W($bits(payload_t))) u_skid (
      .Clk       (Clk),
      .Reset     (Reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_p),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (main_p),
      .skid_data (skid_p),
      .main_fix  (main_fix),
      .skid_fix  (skid_fix)
   );

   assign ID_EX_RegWrite      = out_valid & main_p.regwrite;
   assign ID_EX_ALUSrc        = main_p.alusrc;
   assign ID_EX_Read_Data     = main_p.read_data;
   assign ID_EX_Imm_Data      = main_p.imm;
   assign ID_EX_Read_Reg_Num  = main_p.read_reg;
   assign ID_EX_Write_Reg_Num = main_p.write_reg;
endmodule
